// File: rtl/bst_walk_engine_pkg.sv
// bst_walk_engine_pkg: command/status codes, node flag layout and FSM states shared by the BST walk engine.
package bst_walk_engine_pkg;
    localparam logic [7:0] INSERT_TOKEN = 8'h01;
    localparam logic [7:0] SEARCH_TOKEN = 8'h02;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_FULL      = 2'd2,
        ST_ERROR     = 2'd3
    } status_e;

    typedef struct packed {
        logic used;
        logic is_root;
        logic has_left;
        logic has_right;
    } node_flags_t;

    typedef enum logic [3:0] {
        S_IDLE, S_ALLOC, S_RD_REQ, S_RD_WAIT, S_CMP, S_WR_UPD, S_WR_NEW, S_WR_PARENT, S_CPL
    } state_e;

    function automatic int node_width(input int tw, input int pw, input int aw);
        return pw + 4 + 3 * aw + tw;
    endfunction
endpackage

// File: rtl/bst_walk_engine_codec.sv
// bst_node_codec: packs/unpacks a node word {payload, flags, parent, left, right, token}.
module bst_node_codec import bst_walk_engine_pkg::*; #(
    parameter int TOKEN_WIDTH    = 8,
    parameter int PAYLOAD_WIDTH  = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    localparam int RAM_DATA_WIDTH = node_width(TOKEN_WIDTH, PAYLOAD_WIDTH, RAM_ADDR_WIDTH)
) (
    input  logic [RAM_DATA_WIDTH-1:0] word_in,
    output logic [PAYLOAD_WIDTH-1:0]  dec_payload,
    output node_flags_t               dec_flags,
    output logic [RAM_ADDR_WIDTH-1:0] dec_parent,
    output logic [RAM_ADDR_WIDTH-1:0] dec_left,
    output logic [RAM_ADDR_WIDTH-1:0] dec_right,
    output logic [TOKEN_WIDTH-1:0]    dec_token,
    input  logic [PAYLOAD_WIDTH-1:0]  enc_payload,
    input  node_flags_t               enc_flags,
    input  logic [RAM_ADDR_WIDTH-1:0] enc_parent,
    input  logic [RAM_ADDR_WIDTH-1:0] enc_left,
    input  logic [RAM_ADDR_WIDTH-1:0] enc_right,
    input  logic [TOKEN_WIDTH-1:0]    enc_token,
    output logic [RAM_DATA_WIDTH-1:0] word_out
);
    assign {dec_payload, dec_flags, dec_parent, dec_left, dec_right, dec_token} = word_in;
    assign word_out = {enc_payload, enc_flags, enc_parent, enc_left, enc_right, enc_token};
endmodule

// File: rtl/bst_walk_engine.sv
// bst_walk_engine: executes INSERT_TOKEN / SEARCH_TOKEN by walking a BST held in node RAM,
// allocating new nodes from the tree manager and reporting each command on the completion channel.
module bst_walk_engine import bst_walk_engine_pkg::*; #(
    parameter int TOKEN_WIDTH    = 8,
    parameter int PAYLOAD_WIDTH  = 32,
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int MAX_DEPTH      = 255,
    localparam int RAM_DATA_WIDTH = node_width(TOKEN_WIDTH, PAYLOAD_WIDTH, RAM_ADDR_WIDTH)
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      itf_valid,
    output logic                      itf_ready,
    input  logic [7:0]                itf_cmd,
    input  logic [TOKEN_WIDTH-1:0]    itf_token,
    input  logic [PAYLOAD_WIDTH-1:0]  itf_data,
    output logic                      cpl_valid,
    input  logic                      cpl_ready,
    output logic [1:0]                cpl_status,
    output logic [PAYLOAD_WIDTH-1:0]  cpl_data,
    output logic                      tree_mgt_req_valid,
    input  logic                      tree_mgt_req_ready,
    input  logic [RAM_ADDR_WIDTH-1:0] tree_mgt_req_addr,
    input  logic                      tree_mgt_full,
    output logic                      mem_valid,
    input  logic                      mem_ready,
    output logic                      mem_rd,
    output logic                      mem_wr,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr,
    output logic [RAM_DATA_WIDTH-1:0] mem_wr_data,
    input  logic                      mem_rd_valid,
    input  logic [RAM_DATA_WIDTH-1:0] mem_rd_data
);
    localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

    state_e                    state, state_n;
    status_e                   status_q, status_n;
    logic                      live, root_valid, dir_left;
    logic [7:0]                cmd_q, cmd;
    logic [TOKEN_WIDTH-1:0]    token_q;
    logic [PAYLOAD_WIDTH-1:0]  data_q, cpl_data_q, cpl_data_n;
    logic [RAM_ADDR_WIDTH-1:0] cur, new_addr, root_addr, child;
    logic [DEPTH_W-1:0]        depth;
    logic [RAM_DATA_WIDTH-1:0] node_q, word_out;
    logic                      cmd_acc, is_ins, is_srch, hit, go_left, has_child, at_limit, wr_new, wr_par;

    logic [PAYLOAD_WIDTH-1:0]  n_payload, w_payload;
    node_flags_t               n_flags, w_flags;
    logic [RAM_ADDR_WIDTH-1:0] n_parent, n_left, n_right, w_parent, w_left, w_right;
    logic [TOKEN_WIDTH-1:0]    n_token, w_token;

    bst_node_codec #(
        .TOKEN_WIDTH   (TOKEN_WIDTH),
        .PAYLOAD_WIDTH (PAYLOAD_WIDTH),
        .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH)
    ) u_codec (
        .word_in    (node_q),
        .dec_payload(n_payload),
        .dec_flags  (n_flags),
        .dec_parent (n_parent),
        .dec_left   (n_left),
        .dec_right  (n_right),
        .dec_token  (n_token),
        .enc_payload(w_payload),
        .enc_flags  (w_flags),
        .enc_parent (w_parent),
        .enc_left   (w_left),
        .enc_right  (w_right),
        .enc_token  (w_token),
        .word_out   (word_out)
    );

    assign cmd       = (state == S_IDLE) ? itf_cmd : cmd_q;
    assign is_ins    = cmd == INSERT_TOKEN;
    assign is_srch   = cmd == SEARCH_TOKEN;
    assign cmd_acc   = itf_valid && itf_ready;
    assign hit       = token_q == n_token;
    assign go_left   = token_q < n_token;
    assign has_child = go_left ? n_flags.has_left : n_flags.has_right;
    assign child     = go_left ? n_left : n_right;
    assign at_limit  = depth == DEPTH_W'(MAX_DEPTH);
    assign wr_new    = state == S_WR_NEW;
    assign wr_par    = state == S_WR_PARENT;

    // New nodes start as leaves; parent rewrite keeps its word and only links the new child.
    assign w_payload = wr_par ? n_payload : data_q;
    assign w_flags   = wr_new ? {1'b1, !root_valid, 2'b00}
                              : {n_flags.used, n_flags.is_root, n_flags.has_left | (wr_par && dir_left),
                                 n_flags.has_right | (wr_par && !dir_left)};
    assign w_parent  = wr_new ? (root_valid ? cur : '0) : n_parent;
    assign w_left    = wr_new ? '0 : (wr_par && dir_left) ? new_addr : n_left;
    assign w_right   = wr_new ? '0 : (wr_par && !dir_left) ? new_addr : n_right;
    assign w_token   = wr_new ? token_q : n_token;

    assign itf_ready          = (state == S_IDLE) && live;
    assign tree_mgt_req_valid = (state == S_ALLOC) && !tree_mgt_full;
    assign mem_rd             = state == S_RD_REQ;
    assign mem_wr             = (state == S_WR_UPD) || wr_new || wr_par;
    assign mem_valid          = mem_rd || mem_wr;
    assign mem_addr           = wr_new ? new_addr : (mem_valid ? cur : '0);
    assign mem_wr_data        = mem_wr ? word_out : '0;
    assign cpl_valid          = state == S_CPL;
    assign cpl_status         = status_q;
    assign cpl_data           = cpl_data_q;

    always_comb begin
        state_n    = state;
        status_n   = ST_OK;
        cpl_data_n = '0;
        case (state)
            S_IDLE: if (cmd_acc) begin
                if (is_ins) state_n = root_valid ? S_RD_REQ : S_ALLOC;
                else if (is_srch) begin
                    state_n  = root_valid ? S_RD_REQ : S_CPL;
                    status_n = ST_NOT_FOUND;
                end else begin
                    state_n  = S_CPL;
                    status_n = ST_ERROR;
                end
            end
            S_ALLOC: if (tree_mgt_full) begin
                state_n  = S_CPL;
                status_n = ST_FULL;
            end else if (tree_mgt_req_ready) state_n = S_WR_NEW;
            S_RD_REQ:  if (mem_ready) state_n = S_RD_WAIT;
            S_RD_WAIT: if (mem_rd_valid) state_n = S_CMP;
            S_CMP: if (hit) begin
                state_n    = is_ins ? S_WR_UPD : S_CPL;
                cpl_data_n = n_payload;
            end else if (!has_child) begin
                state_n  = is_ins ? S_ALLOC : S_CPL;
                status_n = ST_NOT_FOUND;
            end else if (at_limit) begin
                state_n  = S_CPL;
                status_n = ST_ERROR;
            end else state_n = S_RD_REQ;
            S_WR_UPD, S_WR_PARENT: if (mem_ready) begin
                state_n    = S_CPL;
                cpl_data_n = data_q;
            end
            S_WR_NEW: if (mem_ready) begin
                state_n    = root_valid ? S_WR_PARENT : S_CPL;
                cpl_data_n = data_q;
            end
            S_CPL:   if (cpl_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            status_q   <= ST_OK;
            live       <= 1'b0;
            root_valid <= 1'b0;
            root_addr  <= '0;
            dir_left   <= 1'b0;
            cmd_q      <= '0;
            token_q    <= '0;
            data_q     <= '0;
            cpl_data_q <= '0;
            cur        <= '0;
            new_addr   <= '0;
            depth      <= '0;
            node_q     <= '0;
        end else begin
            live  <= 1'b1;
            state <= state_n;
            if (state_n == S_CPL && state != S_CPL) begin
                status_q   <= status_n;
                cpl_data_q <= cpl_data_n;
            end
            if (cmd_acc) begin
                cmd_q   <= itf_cmd;
                token_q <= itf_token;
                data_q  <= itf_data;
                cur     <= root_addr;
                depth   <= '0;
            end
            if (tree_mgt_req_valid && tree_mgt_req_ready) new_addr <= tree_mgt_req_addr;
            if (state == S_RD_WAIT && mem_rd_valid) begin
                node_q <= mem_rd_data;
                depth  <= depth + DEPTH_W'(1);
            end
            // cur stays on the matched/leaf node so the following write targets it.
            if (state == S_CMP) begin
                dir_left <= go_left;
                if (!hit && has_child && !at_limit) cur <= child;
            end
            if (wr_new && mem_ready && !root_valid) begin
                root_valid <= 1'b1;
                root_addr  <= new_addr;
            end
        end
    end
endmodule
